reaction_controller: RTL and testbench
======================================

Name: reaction_controller

Overview:
- Sequencing FSM for the reaction-time datapath: random down-count, up-count and score load.
- Watches the player pushbutton and drives the count-start and score-load strobes and the screen colour code.
- Detects false starts and timeouts, runs NUM_ROUNDS scored rounds, and accumulates a sum and average for the top-level display.

Parameters:
- NUM_ROUNDS, 5, scored rounds per session (1..7).
- TIMEOUT_MS, 2000, ms in GO before the round is abandoned (< 4095).
- HOLD_MS, 1000, ms the result or error screen is held.

Ports:
- clk  in  1  system clock (50 MHz).
- iReset  in  1  asynchronous, active-high reset.
- iButton  in  1  raw pushbutton, active-high, asynchronous to clk.
- iMs_tick  in  1  one-clk pulse every 1 ms, from the datapath rate divider.
- iCountComplete  in  1  random down-count expired.
- iUpCount  in  12  current reaction count in ms.
- oStart_down_count  out  1  reload random down-counter.
- oStart_up_count  out  1  clear up-counter.
- oLoad_score  out  1  one-clk score capture strobe.
- oScreen  out  2  colour code: 0 idle, 1 wait/red, 2 go/green, 3 result.
- oFalseStart  out  1  high while the false-start screen is shown.
- oTimeout  out  1  high while the timeout screen is shown.
- oRound  out  3  scored rounds completed.
- oSum  out  15  sum of scored reaction times.
- oAverage  out  12  oSum / NUM_ROUNDS, valid when oDone = 1.
- oDone  out  1  session complete.

Behaviour:
- Reset (async, iReset=1):
  - state = IDLE.
  - All outputs 0, including oRound, oSum, oAverage and oDone.
  - Hold counter and button synchroniser flops cleared.
- Button input:
  - 2-flop synchroniser, then rising-edge detect.
  - The single-clk `press` pulse occurs 3 clk after a raw rising edge.
  - Holding the button produces exactly one press.
- Strobe stretching: the datapath counters run on the ms tick, so start strobes are held until a tick is seen.
  - ARM and GO_ARM assert their strobe continuously.
  - They exit on the clk after the cycle in which iMs_tick=1.
- IDLE:
  - oScreen=0.
  - press -> ARM; oRound and oSum are cleared on this transition.
- ARM:
  - oScreen=1, oStart_down_count=1.
  - iMs_tick -> WAIT.
  - press in ARM -> FALSE.
- WAIT:
  - oScreen=1.
  - press -> FALSE. press has priority over iCountComplete when both occur in the same cycle.
  - iCountComplete -> GO_ARM.
- GO_ARM:
  - oScreen=2, oStart_up_count=1.
  - iMs_tick -> GO.
  - press -> LOAD, which captures the 0 count; this is legal.
- GO:
  - oScreen=2.
  - press -> LOAD.
  - else if iUpCount >= TIMEOUT_MS -> TOUT.
- LOAD (exactly 1 clk):
  - oLoad_score=1, oScreen=2.
  - oSum += iUpCount, oRound += 1.
  - -> SHOW.
- SHOW:
  - oScreen=3.
  - Hold counter counts iMs_tick. When it reaches HOLD_MS:
    - if oRound == NUM_ROUNDS -> DONE;
    - else -> ARM.
  - Hold counter clears on every state entry.
- FALSE:
  - oScreen=3, oFalseStart=1.
  - No score, oRound unchanged.
  - After HOLD_MS ticks -> ARM (round retried).
- TOUT:
  - oScreen=3, oTimeout=1.
  - No score, oRound unchanged.
  - After HOLD_MS ticks -> ARM.
- DONE:
  - oScreen=3, oDone=1.
  - oAverage = oSum / NUM_ROUNDS (integer truncation), registered on DONE entry.
  - press -> IDLE-entry path: go directly to ARM with oRound, oSum and oAverage cleared and oDone deasserted.
- Presses in SHOW/FALSE/TOUT are ignored.
- Arithmetic: oSum is 15 bits. The maximum 7*4095 = 28665 fits, so no overflow handling is required.
- Reset mid-operation: immediate return to IDLE, all strobes drop asynchronously.

Test Plan:
- Reset mid-GO (oScreen=2): assert iReset -> same-cycle oScreen=0, strobes 0, oRound=0.
- Normal round: press in IDLE -> oStart_down_count high until the first tick, then exactly 1 clk later state WAIT; iCountComplete -> oStart_up_count held to next tick; press with iUpCount=250 -> one oLoad_score pulse, oSum=250, oRound=1, oScreen=3 for 1000 ticks, then ARM.
- False start: press in WAIT coincident with iCountComplete -> oFalseStart=1, no oLoad_score, oRound unchanged, re-ARM after 1000 ticks.
- Timeout: no press in GO, iUpCount reaches 2000 -> oTimeout=1, oSum unchanged.
- Session: 5 scored rounds of 200,300,400,500,601 -> oSum=2001, oDone=1, oAverage=400; then press -> oDone=0, oRound=0, state ARM.
- Button held 10 ms in WAIT->GO transition -> only one press recognised, glitch-free single load.

Source files
------------

// File: rtl/reaction_controller_if.sv
`timescale 1ns/1ps
// reaction_controller_if
//   Carries the signals between the reaction-game sequencer and the rest
//   of the system: pushbutton, ms tick, datapath status, strobes and the
//   score/display results.
//   master : drives the inputs (button, tick, datapath status), reads results
//   slave  : the controller itself
interface reaction_controller_if;
  logic        iButton;
  logic        iMs_tick;
  logic        iCountComplete;
  logic [11:0] iUpCount;
  logic        oStart_down_count;
  logic        oStart_up_count;
  logic        oLoad_score;
  logic [1:0]  oScreen;
  logic        oFalseStart;
  logic        oTimeout;
  logic [2:0]  oRound;
  logic [14:0] oSum;
  logic [11:0] oAverage;
  logic        oDone;

  modport master (
    output iButton, iMs_tick, iCountComplete, iUpCount,
    input  oStart_down_count, oStart_up_count, oLoad_score, oScreen,
           oFalseStart, oTimeout, oRound, oSum, oAverage, oDone
  );

  modport slave (
    input  iButton, iMs_tick, iCountComplete, iUpCount,
    output oStart_down_count, oStart_up_count, oLoad_score, oScreen,
           oFalseStart, oTimeout, oRound, oSum, oAverage, oDone
  );
endinterface

// File: rtl/reaction_controller.sv
`timescale 1ns/1ps
// reaction_controller
//   Sequencing FSM for the reaction-time game. Synchronises the pushbutton,
//   strobes the random down-counter and the reaction up-counter, captures
//   scores, detects false starts and timeouts, and accumulates the session
//   sum and average over NUM_ROUNDS scored rounds.
// Ports:
//   clk     : system clock
//   iReset  : asynchronous active-high reset
//   bus     : reaction_controller_if.slave
//     iButton (raw, async), iMs_tick (1 ms pulse), iCountComplete,
//     iUpCount[11:0] -> oStart_down_count, oStart_up_count, oLoad_score,
//     oScreen[1:0] (0 idle, 1 wait, 2 go, 3 result), oFalseStart, oTimeout,
//     oRound[2:0], oSum[14:0], oAverage[11:0], oDone
module reaction_controller #(
  parameter int NUM_ROUNDS = 5,
  parameter int TIMEOUT_MS = 2000,
  parameter int HOLD_MS    = 1000
) (
  input  logic                  clk,
  input  logic                  iReset,
  reaction_controller_if.slave  bus
);

  localparam int                HOLD_W      = $clog2(HOLD_MS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_MS - 1);
  localparam logic [11:0]       TIMEOUT_VAL = 12'(TIMEOUT_MS);
  localparam logic [2:0]        ROUNDS_VAL  = 3'(NUM_ROUNDS);
  localparam logic [14:0]       ROUNDS_DIV  = 15'(NUM_ROUNDS);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_WAIT, S_GO_ARM, S_GO, S_LOAD, S_SHOW, S_FALSE, S_TOUT, S_DONE
  } state_t;

  state_t state, state_next;

  logic btn_meta, btn_sync, btn_prev;
  logic press;

  logic [HOLD_W-1:0] hold_cnt;
  logic              holding;
  logic              hold_done;

  logic [2:0]  round_q;
  logic [14:0] sum_q;
  logic [11:0] avg_q;
  logic        session_clear;

  logic       start_down, start_up, load_score, false_start, timeout, done;
  logic [1:0] screen;

  // Two flops resolve metastability; the third holds the previous level so a
  // held button yields a single-cycle press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= bus.iButton;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign press = btn_sync & ~btn_prev;

  assign holding   = (state == S_SHOW) || (state == S_FALSE) || (state == S_TOUT);
  assign hold_done = bus.iMs_tick && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    screen      = 2'd0;
    start_down  = 1'b0;
    start_up    = 1'b0;
    load_score  = 1'b0;
    false_start = 1'b0;
    timeout     = 1'b0;
    done        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (press) state_next = S_ARM;
      end
      S_ARM: begin
        // Strobe held until the tick-driven down-counter has seen it.
        screen     = 2'd1;
        start_down = 1'b1;
        if (press)             state_next = S_FALSE;
        else if (bus.iMs_tick) state_next = S_WAIT;
      end
      S_WAIT: begin
        screen = 2'd1;
        // A press wins over a coincident count expiry: that is a false start.
        if (press)                   state_next = S_FALSE;
        else if (bus.iCountComplete) state_next = S_GO_ARM;
      end
      S_GO_ARM: begin
        screen   = 2'd2;
        start_up = 1'b1;
        if (press)             state_next = S_LOAD;
        else if (bus.iMs_tick) state_next = S_GO;
      end
      S_GO: begin
        screen = 2'd2;
        if (press)                          state_next = S_LOAD;
        else if (bus.iUpCount >= TIMEOUT_VAL) state_next = S_TOUT;
      end
      S_LOAD: begin
        screen     = 2'd2;
        load_score = 1'b1;
        state_next = S_SHOW;
      end
      S_SHOW: begin
        screen = 2'd3;
        // round_q already includes the score captured in LOAD.
        if (hold_done) state_next = (round_q == ROUNDS_VAL) ? S_DONE : S_ARM;
      end
      S_FALSE: begin
        screen      = 2'd3;
        false_start = 1'b1;
        if (hold_done) state_next = S_ARM;
      end
      S_TOUT: begin
        screen  = 2'd3;
        timeout = 1'b1;
        if (hold_done) state_next = S_ARM;
      end
      S_DONE: begin
        screen = 2'd3;
        done   = 1'b1;
        if (press) state_next = S_ARM;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A press in IDLE or DONE starts a fresh session.
  assign session_clear = press && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      hold_cnt <= '0;
      round_q  <= '0;
      sum_q    <= '0;
      avg_q    <= '0;
    end else begin
      if (state_next != state)   hold_cnt <= '0;
      else if (holding && bus.iMs_tick) hold_cnt <= hold_cnt + 1'b1;

      if (session_clear) begin
        round_q <= '0;
        sum_q   <= '0;
        avg_q   <= '0;
      end else if (state == S_LOAD) begin
        round_q <= round_q + 3'd1;
        sum_q   <= sum_q + 15'(bus.iUpCount);
      end

      // The sum is final by the time SHOW hands over to DONE.
      if ((state_next == S_DONE) && (state != S_DONE)) avg_q <= 12'(sum_q / ROUNDS_DIV);
    end
  end

  assign bus.oScreen           = screen;
  assign bus.oStart_down_count = start_down;
  assign bus.oStart_up_count   = start_up;
  assign bus.oLoad_score       = load_score;
  assign bus.oFalseStart       = false_start;
  assign bus.oTimeout          = timeout;
  assign bus.oDone             = done;
  assign bus.oRound            = round_q;
  assign bus.oSum              = sum_q;
  assign bus.oAverage          = avg_q;

endmodule

// File: tb/tb_reaction_controller.sv
`timescale 1ns/1ps
// tb_reaction_controller
//   Scenario tasks run in sequence from one initial block. Expected scores
//   are queued when a press is driven in GO and compared one cycle after
//   the DUT pulses oLoad_score.
module tb_reaction_controller;

  logic clk = 1'b0;
  logic iReset;

  reaction_controller_if bus ();

  reaction_controller dut (
    .clk    (clk),
    .iReset (iReset),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [14:0] sum;
    logic [2:0]  round;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic        tick_en      = 1'b0;
  logic        load_pending = 1'b0;
  logic [14:0] model_sum    = '0;
  logic [2:0]  model_round  = '0;

  // Advance one clock; sample 1 ns after the edge, then drive the ms tick.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (load_pending) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_load: got load with sum=%0d round=%0d, required no load", bus.oSum, bus.oRound);
      end else begin
        e = exp_q.pop_front();
        if ({bus.oSum, bus.oRound} !== {e.sum, e.round}) begin
          tests_failed++;
          $display("FAIL sb_score: got sum=%0d round=%0d, required sum=%0d round=%0d", bus.oSum, bus.oRound, e.sum, e.round);
        end
      end
    end
    load_pending = bus.oLoad_score;
    if (tick_en) bus.iMs_tick = !bus.iMs_tick;
  endtask

  // Raw rising edge; the FSM reacts on the third edge after it.
  task automatic press();
    bus.iButton = 1'b1;
    repeat (3) cycle();
    bus.iButton = 1'b0;
  endtask

  function automatic logic state_match(input int which);
    case (which)
      0:       return (bus.oScreen == 2'd1) && !bus.oStart_down_count; // WAIT
      1:       return (bus.oScreen == 2'd2) && !bus.oStart_up_count;   // GO
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_state(input int which, input string name);
    int n = 0;
    tests_run++;
    while (!state_match(which) && n < 200) begin
      cycle();
      n++;
    end
    if (!state_match(which)) begin
      tests_failed++;
      $display("FAIL %s: screen=%0d still not reached after 200 cycles", name, bus.oScreen);
    end
  endtask

  // Counts the ticks the DUT samples while a result/error screen is up.
  task automatic wait_hold(output int ticks);
    int n = 0;
    ticks = 0;
    while (bus.oScreen == 2'd3 && !bus.oDone && n < 5000) begin
      if (bus.iMs_tick) ticks++;
      cycle();
      n++;
    end
  endtask

  task automatic reach_go();
    tick_en = 1'b1;
    bus.iUpCount = 12'd0;
    wait_state(0, "reach_wait");
    bus.iCountComplete = 1'b1;
    cycle();
    bus.iCountComplete = 1'b0;
    wait_state(1, "reach_go");
  endtask

  task automatic queue_score(input logic [11:0] count);
    model_sum   = model_sum + 15'(count);
    model_round = model_round + 3'd1;
    exp_q.push_back('{model_sum, model_round});
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    bus.iButton = 1'b0;
    bus.iMs_tick = 1'b0;
    bus.iCountComplete = 1'b0;
    bus.iUpCount = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.oScreen, bus.oStart_down_count, bus.oStart_up_count, bus.oLoad_score, bus.oFalseStart,
         bus.oTimeout, bus.oDone, bus.oRound, bus.oSum, bus.oAverage} !== 38'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got screen=%0d round=%0d sum=%0d avg=%0d done=%0d, required all 0",
               bus.oScreen, bus.oRound, bus.oSum, bus.oAverage, bus.oDone);
    end
    iReset = 1'b0;
    repeat (4) cycle();
    tests_run++;
    if (bus.oScreen !== 2'd0) begin
      tests_failed++;
      $display("FAIL idle_hold: got screen=%0d, required 0", bus.oScreen);
    end
  endtask

  task automatic test_normal_round();
    int ticks;
    press();
    model_sum = '0;
    model_round = '0;
    tests_run++;
    if ({bus.oScreen, bus.oStart_down_count, bus.oStart_up_count} !== {2'd1, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL arm_entry: got screen/down/up=%b, required 0110", {bus.oScreen, bus.oStart_down_count, bus.oStart_up_count});
    end
    repeat (5) cycle();
    tests_run++;
    if (bus.oStart_down_count !== 1'b1) begin
      tests_failed++;
      $display("FAIL arm_stretch: got down=%b, required 1", bus.oStart_down_count);
    end
    bus.iMs_tick = 1'b1;
    cycle();
    bus.iMs_tick = 1'b0;
    tests_run++;
    if ({bus.oScreen, bus.oStart_down_count} !== {2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL arm_to_wait: got screen/down=%b, required 010", {bus.oScreen, bus.oStart_down_count});
    end
    bus.iCountComplete = 1'b1;
    cycle();
    bus.iCountComplete = 1'b0;
    repeat (4) cycle();
    tests_run++;
    if ({bus.oScreen, bus.oStart_up_count} !== {2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL go_arm_stretch: got screen/up=%b, required 101", {bus.oScreen, bus.oStart_up_count});
    end
    bus.iMs_tick = 1'b1;
    cycle();
    bus.iMs_tick = 1'b0;
    tests_run++;
    if ({bus.oScreen, bus.oStart_up_count} !== {2'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL go_arm_to_go: got screen/up=%b, required 100", {bus.oScreen, bus.oStart_up_count});
    end
    bus.iUpCount = 12'd250;
    queue_score(12'd250);
    press();
    tests_run++;
    if ({bus.oScreen, bus.oLoad_score} !== {2'd2, 1'b1}) begin
      tests_failed++;
      $display("FAIL load_pulse: got screen/load=%b, required 101", {bus.oScreen, bus.oLoad_score});
    end
    cycle();
    tests_run++;
    if ({bus.oScreen, bus.oLoad_score, bus.oSum, bus.oRound} !== {2'd3, 1'b0, 15'd250, 3'd1}) begin
      tests_failed++;
      $display("FAIL show_entry: got screen=%0d load=%b sum=%0d round=%0d, required 3 0 250 1",
               bus.oScreen, bus.oLoad_score, bus.oSum, bus.oRound);
    end
    tick_en = 1'b1;
    wait_hold(ticks);
    tests_run++;
    if (ticks != 1000 || {bus.oScreen, bus.oStart_down_count} !== {2'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL show_hold: got ticks=%0d screen=%0d down=%b, required 1000 1 1", ticks, bus.oScreen, bus.oStart_down_count);
    end
  endtask

  task automatic test_false_start();
    int ticks;
    tick_en = 1'b1;
    wait_state(0, "fs_wait");
    tick_en = 1'b0;
    bus.iMs_tick = 1'b0;
    bus.iButton = 1'b1;
    cycle();
    cycle();
    bus.iCountComplete = 1'b1;  // coincides with the press pulse
    cycle();
    bus.iCountComplete = 1'b0;
    bus.iButton = 1'b0;
    tests_run++;
    if ({bus.oScreen, bus.oFalseStart, bus.oLoad_score, bus.oRound} !== {2'd3, 1'b1, 1'b0, 3'd1}) begin
      tests_failed++;
      $display("FAIL false_entry: got screen=%0d false=%b load=%b round=%0d, required 3 1 0 1",
               bus.oScreen, bus.oFalseStart, bus.oLoad_score, bus.oRound);
    end
    tick_en = 1'b1;
    wait_hold(ticks);
    tests_run++;
    if (ticks != 1000 || {bus.oScreen, bus.oStart_down_count, bus.oFalseStart, bus.oRound} !== {2'd1, 1'b1, 1'b0, 3'd1}) begin
      tests_failed++;
      $display("FAIL false_hold: got ticks=%0d screen=%0d false=%b round=%0d, required 1000 1 0 1",
               ticks, bus.oScreen, bus.oFalseStart, bus.oRound);
    end
  endtask

  task automatic test_timeout();
    int ticks;
    reach_go();
    bus.iUpCount = 12'd1999;
    repeat (5) cycle();
    tests_run++;
    if ({bus.oScreen, bus.oTimeout} !== {2'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_early: got screen=%0d tout=%b at 1999, required 2 0", bus.oScreen, bus.oTimeout);
    end
    bus.iUpCount = 12'd2000;
    cycle();
    tests_run++;
    if ({bus.oScreen, bus.oTimeout, bus.oSum, bus.oRound} !== {2'd3, 1'b1, 15'd250, 3'd1}) begin
      tests_failed++;
      $display("FAIL timeout_entry: got screen=%0d tout=%b sum=%0d round=%0d, required 3 1 250 1",
               bus.oScreen, bus.oTimeout, bus.oSum, bus.oRound);
    end
    wait_hold(ticks);
    tests_run++;
    if (ticks != 1000 || {bus.oScreen, bus.oTimeout} !== {2'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL timeout_hold: got ticks=%0d screen=%0d tout=%b, required 1000 1 0", ticks, bus.oScreen, bus.oTimeout);
    end
  endtask

  task automatic test_reset_mid_go();
    tick_en = 1'b1;
    wait_state(0, "rst_wait");
    bus.iCountComplete = 1'b1;
    cycle();
    bus.iCountComplete = 1'b0;
    tick_en = 1'b0;
    bus.iMs_tick = 1'b0;
    tests_run++;
    if ({bus.oScreen, bus.oStart_up_count, bus.oRound} !== {2'd2, 1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL rst_pre: got screen=%0d up=%b round=%0d, required 2 1 1", bus.oScreen, bus.oStart_up_count, bus.oRound);
    end
    iReset = 1'b1;
    #1;
    tests_run++;
    if ({bus.oScreen, bus.oStart_down_count, bus.oStart_up_count, bus.oLoad_score, bus.oRound, bus.oSum} !== 22'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got screen=%0d up=%b round=%0d sum=%0d, required all 0",
               bus.oScreen, bus.oStart_up_count, bus.oRound, bus.oSum);
    end
    repeat (2) @(posedge clk);
    #1;
    iReset = 1'b0;
    load_pending = 1'b0;
    model_sum = '0;
    model_round = '0;
    cycle();
  endtask

  task automatic test_session();
    int ticks;
    logic [11:0] vals [5];
    vals = '{12'd200, 12'd300, 12'd400, 12'd500, 12'd601};
    tick_en = 1'b1;
    press();
    tests_run++;
    if ({bus.oScreen, bus.oRound, bus.oSum} !== {2'd1, 3'd0, 15'd0}) begin
      tests_failed++;
      $display("FAIL session_start: got screen=%0d round=%0d sum=%0d, required 1 0 0", bus.oScreen, bus.oRound, bus.oSum);
    end
    for (int i = 0; i < 5; i++) begin
      reach_go();
      bus.iUpCount = vals[i];
      queue_score(vals[i]);
      press();
      cycle();
      wait_hold(ticks);
      tests_run++;
      if (ticks != 1000 || bus.oDone !== (i == 4)) begin
        tests_failed++;
        $display("FAIL session_round%0d: got ticks=%0d done=%b, required 1000 %b", i, ticks, bus.oDone, (i == 4));
      end
    end
    tests_run++;
    if ({bus.oDone, bus.oRound, bus.oSum, bus.oAverage, bus.oScreen} !== {1'b1, 3'd5, 15'd2001, 12'd400, 2'd3}) begin
      tests_failed++;
      $display("FAIL session_done: got done=%b round=%0d sum=%0d avg=%0d screen=%0d, required 1 5 2001 400 3",
               bus.oDone, bus.oRound, bus.oSum, bus.oAverage, bus.oScreen);
    end
    press();
    model_sum = '0;
    model_round = '0;
    tests_run++;
    if ({bus.oDone, bus.oRound, bus.oSum, bus.oAverage, bus.oScreen, bus.oStart_down_count} !==
        {1'b0, 3'd0, 15'd0, 12'd0, 2'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL session_restart: got done=%b round=%0d sum=%0d avg=%0d screen=%0d, required 0 0 0 0 1",
               bus.oDone, bus.oRound, bus.oSum, bus.oAverage, bus.oScreen);
    end
  endtask

  // Press in GO_ARM (zero count is legal) and keep the button down through
  // the whole result screen and back into ARM.
  task automatic test_held_button();
    int ticks;
    int fs = 0;
    tick_en = 1'b1;
    bus.iUpCount = 12'd0;
    wait_state(0, "held_wait");
    bus.iCountComplete = 1'b1;
    cycle();
    bus.iCountComplete = 1'b0;
    tick_en = 1'b0;
    bus.iMs_tick = 1'b0;
    queue_score(12'd0);
    bus.iButton = 1'b1;
    repeat (3) cycle();
    cycle();
    tick_en = 1'b1;
    wait_hold(ticks);
    repeat (40) begin
      cycle();
      if (bus.oFalseStart) fs++;
    end
    bus.iButton = 1'b0;
    tests_run++;
    if (ticks != 1000 || fs != 0 || {bus.oRound, bus.oSum} !== {3'd1, 15'd0}) begin
      tests_failed++;
      $display("FAIL held_button: got ticks=%0d false_cycles=%0d round=%0d sum=%0d, required 1000 0 1 0",
               ticks, fs, bus.oRound, bus.oSum);
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d scores never loaded, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_false_start();
    test_timeout();
    test_reset_mid_go();
    test_session();
    test_held_button();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
